uart_xcvr: RTL and testbench
============================

Name: uart_xcvr

Overview:
Parametrised full-duplex UART transceiver, successor to the fixed 16-bit command UART. The transmitter serialises a NUM_BYTES-wide command as consecutive frames. Each frame is start, DATA_W data bits LSB first, optional parity, then one stop bit, with bit timing set by a clock divider. The receiver runs independently with a double-flop synchroniser, a mid-bit sampler, start-glitch rejection and per-frame parity/framing error flags; it sits between the command bus and the chip's serial pins.

Parameters:
CLK_DIV, 16, clk cycles per serial bit; minimum 4, must be even.
DATA_W, 8, data bits per frame; range 5..9.
NUM_BYTES, 2, frames per TX command.
PARITY, 1, parity mode: 0 = none, 1 = odd, 2 = even.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_in  in  NUM_BYTES*DATA_W  TX command word
cmd_vld  in  1  command valid
cmd_rdy  out  1  transmitter idle / can accept
tx  out  1  serial output, idle high
rx  in  1  serial input, asynchronous
read_data  out  DATA_W  last received data
read_vld  out  1  one-cycle pulse: read_data and the error flags are valid
parity_err  out  1  parity mismatch on the current read_vld frame
frame_err  out  1  stop bit sampled 0 on the current read_vld frame

Behaviour:
- Reset values: tx=1, cmd_rdy=1, read_vld=0, read_data=0, parity_err=0, frame_err=0, both FSMs in IDLE, all counters 0.
- TX accept: a command is accepted on a clk edge where cmd_vld && cmd_rdy.
  - cmd_in is captured into a shift register.
  - cmd_rdy goes 0 on the next cycle.
  - cmd_vld while cmd_rdy=0 is ignored; the captured word is never altered mid-command.
- TX order: most-significant byte first (cmd_in[NUM_BYTES*DATA_W-1 -: DATA_W]); within each frame, LSB first.
- TX parity: computed from the captured byte. Odd mode: data ones plus parity bit is odd. Even mode: that total is even. PARITY=0: no parity bit.
- TX FSM: IDLE -> START -> DATA (DATA_W bits) -> PARITY (skipped if PARITY=0) -> STOP.
  - After STOP, go back to START if frames remain, otherwise IDLE.
  - Each state bit lasts exactly CLK_DIV cycles; frames are back-to-back with no idle gap.
- TX latency: tx drops to 0 on the cycle after acceptance.
- Frame length: FB = 1 + DATA_W + (PARITY?1:0) + 1 bits.
- TX completion: cmd_rdy returns to 1 exactly NUM_BYTES*FB*CLK_DIV cycles after tx first drops.
  - tx=1 from that cycle on.
  - A new command may be accepted in that same cycle.
- RX synchroniser: rx passes through 2 flops before any use.
- RX FSM: IDLE -> START_CHK -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: wait for synchronised rx=0.
  - START_CHK: sample at CLK_DIV/2 cycles; if the line is 1, discard as a glitch and return to IDLE with no output.
  - Subsequent bits are sampled every CLK_DIV cycles from that midpoint.
- RX output: on the stop-bit sample cycle + 1, read_vld=1 for exactly one cycle.
  - read_data updates in the same cycle; parity_err and frame_err are valid with it.
  - read_data holds its value until the next read_vld.
- Frame error: frame_err=1 if the stop sample is 0; the data is still delivered. The RX FSM then waits for the line to be high before it re-arms in IDLE (break handling).
- Reset mid-operation: all state aborts immediately and outputs take reset values. A partial frame is neither completed nor reported.
- TX and RX are fully independent; simultaneous activity is supported.

Optional Feature:
Macro UART_LOOPBACK_EN.
- Defined: extra input port loop_en (1 bit).
  - loop_en=1: the receiver input is the internal tx bit (bypassing the synchroniser is not allowed; still 2 flops) and the tx pin is held at 1.
  - loop_en=0: normal operation.
- Not defined: the port does not exist and the receiver always uses rx.

Test Plan:
1. CLK_DIV=4, DATA_W=8, NUM_BYTES=2, PARITY=1; cmd_in=16'hA55A, cmd_vld for 1 cycle.
   - Expected: tx carries frame 0xA5 (bits 0,1,0,1,0,0,1,0,1, parity 1, stop 1), then 0x5A with parity 1.
   - Each bit lasts 4 cycles; cmd_rdy=0 for 88 cycles, then 1.
2. Drive rx with 0x3C, odd parity bit 1, stop 1, at CLK_DIV=4.
   - Expected: a single read_vld pulse with read_data=8'h3C, parity_err=0, frame_err=0.
3. Drive rx with 0x01 and parity bit 1 (wrong for odd).
   - Expected: read_vld with read_data=8'h01, parity_err=1.
   - Then drive 0x01 with stop=0: frame_err=1, and no new frame is accepted until rx returns high.
4. rx low pulse of 1 clk (below CLK_DIV/2).
   - Expected: no read_vld, and the RX FSM is back in IDLE.
5. Assert cmd_vld with 16'h1234 during an active command; then assert rst_n=0 mid-frame.
   - Expected: the second cmd_vld is ignored and the original frames are unaltered.
   - On reset: tx=1, cmd_rdy=1 asynchronously, and no read_vld.
6. With UART_LOOPBACK_EN defined and loop_en=1, send 16'hC381.
   - Expected: read_vld twice, with 0xC3 then 0x81, no errors; the tx pin stays 1 throughout.

Source files
------------

// File: rtl/uart_xcvr.sv
// rtl/uart_xcvr.sv - parametrised full-duplex UART transceiver (multi-frame TX command, checked RX)
// Define UART_LOOPBACK_EN to add loop_en, which feeds the internal tx bit to the receiver.
module uart_xcvr #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_W    = 8,
  parameter int NUM_BYTES = 2,
  parameter int PARITY    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef UART_LOOPBACK_EN
  input  logic                        loop_en,
`endif
  input  logic [NUM_BYTES*DATA_W-1:0] cmd_in,
  input  logic                        cmd_vld,
  output logic                        cmd_rdy,
  output logic                        tx,
  input  logic                        rx,
  output logic [DATA_W-1:0]           read_data,
  output logic                        read_vld,
  output logic                        parity_err,
  output logic                        frame_err
);

  localparam int CMD_W = NUM_BYTES * DATA_W;
  localparam int CW    = $clog2(CLK_DIV);
  localparam int BW    = $clog2(DATA_W);
  localparam int NBW   = $clog2(NUM_BYTES + 1);
  localparam logic [CW-1:0]  DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [NBW-1:0] BYTE_LAST = NBW'(NUM_BYTES - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START_CHK, RX_DATA, RX_PAR, RX_STOP, RX_BREAK} rx_state_e;

  tx_state_e         tx_state_q;
  logic [CW-1:0]     tx_cnt_q;
  logic [BW-1:0]     tx_bit_q;
  logic [NBW-1:0]    tx_byte_q;
  logic [CMD_W-1:0]  tx_shreg_q;
  logic [DATA_W-1:0] tx_frame_q;
  logic              tx_q;
  logic              cmd_rdy_q;

  logic [DATA_W-1:0] tx_cur;
  logic              tx_par;
  logic              tx_bit_end;
  logic              rx_src;

  // The top slice of the shift register is always the frame on the wire.
  assign tx_cur     = tx_shreg_q[CMD_W-1 -: DATA_W];
  assign tx_par     = (PARITY == 2) ? ^tx_cur : ~^tx_cur;
  assign tx_bit_end = (tx_cnt_q == DIV_LAST);
  assign cmd_rdy    = cmd_rdy_q;

`ifdef UART_LOOPBACK_EN
  assign tx     = loop_en ? 1'b1 : tx_q;
  assign rx_src = loop_en ? tx_q : rx;
`else
  assign tx     = tx_q;
  assign rx_src = rx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_shreg_q <= '0;
      tx_frame_q <= '0;
      tx_q       <= 1'b1;
      cmd_rdy_q  <= 1'b1;
    end else begin
      if (tx_state_q != TX_IDLE) tx_cnt_q <= tx_bit_end ? '0 : tx_cnt_q + 1'b1;
      unique case (tx_state_q)
        TX_IDLE: if (cmd_vld) begin
          tx_shreg_q <= cmd_in;
          tx_byte_q  <= '0;
          tx_cnt_q   <= '0;
          tx_q       <= 1'b0;
          cmd_rdy_q  <= 1'b0;
          tx_state_q <= TX_START;
        end
        TX_START: if (tx_bit_end) begin
          tx_q       <= tx_cur[0];
          tx_frame_q <= tx_cur >> 1;
          tx_bit_q   <= '0;
          tx_state_q <= TX_DATA;
        end
        TX_DATA: if (tx_bit_end) begin
          if (tx_bit_q == BIT_LAST) begin
            if (PARITY != 0) begin
              tx_q       <= tx_par;
              tx_state_q <= TX_PAR;
            end else begin
              tx_q       <= 1'b1;
              tx_state_q <= TX_STOP;
            end
          end else begin
            tx_q       <= tx_frame_q[0];
            tx_frame_q <= tx_frame_q >> 1;
            tx_bit_q   <= tx_bit_q + 1'b1;
          end
        end
        TX_PAR: if (tx_bit_end) begin
          tx_q       <= 1'b1;
          tx_state_q <= TX_STOP;
        end
        TX_STOP: if (tx_bit_end) begin
          if (tx_byte_q == BYTE_LAST) begin
            cmd_rdy_q  <= 1'b1;
            tx_state_q <= TX_IDLE;
          end else begin
            tx_byte_q  <= tx_byte_q + 1'b1;
            tx_shreg_q <= tx_shreg_q << DATA_W;
            tx_q       <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  rx_state_e         rx_state_q;
  logic              rx_s1_q;
  logic              rx_s2_q;
  logic [CW-1:0]     rx_cnt_q;
  logic [BW-1:0]     rx_bit_q;
  logic [DATA_W-1:0] rx_shreg_q;
  logic              rx_perr_q;
  logic [DATA_W-1:0] read_data_q;
  logic              read_vld_q;
  logic              parity_err_q;
  logic              frame_err_q;
  logic              rx_tick;
  logic              rx_timing;

  // The first tick lands mid start bit; later ticks are a whole bit apart.
  assign rx_tick   = (rx_state_q == RX_START_CHK) ? (rx_cnt_q == HALF_LAST) : (rx_cnt_q == DIV_LAST);
  assign rx_timing = (rx_state_q == RX_START_CHK) || (rx_state_q == RX_DATA) ||
                     (rx_state_q == RX_PAR) || (rx_state_q == RX_STOP);

  assign read_data  = read_data_q;
  assign read_vld   = read_vld_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shreg_q   <= '0;
      rx_perr_q    <= 1'b0;
      read_data_q  <= '0;
      read_vld_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_s1_q    <= rx_src;
      rx_s2_q    <= rx_s1_q;
      read_vld_q <= 1'b0;
      rx_cnt_q   <= (rx_timing && !rx_tick) ? rx_cnt_q + 1'b1 : '0;
      unique case (rx_state_q)
        RX_IDLE: if (!rx_s2_q) rx_state_q <= RX_START_CHK;
        RX_START_CHK: if (rx_tick) begin
          rx_bit_q   <= '0;
          rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_tick) begin
          rx_shreg_q <= {rx_s2_q, rx_shreg_q[DATA_W-1:1]};
          rx_bit_q   <= rx_bit_q + 1'b1;
          rx_perr_q  <= 1'b0;
          if (rx_bit_q == BIT_LAST) rx_state_q <= (PARITY != 0) ? RX_PAR : RX_STOP;
        end
        RX_PAR: if (rx_tick) begin
          rx_perr_q  <= (PARITY == 2) ? (^rx_shreg_q ^ rx_s2_q) : ~(^rx_shreg_q ^ rx_s2_q);
          rx_state_q <= RX_STOP;
        end
        RX_STOP: if (rx_tick) begin
          read_vld_q   <= 1'b1;
          read_data_q  <= rx_shreg_q;
          parity_err_q <= rx_perr_q;
          frame_err_q  <= ~rx_s2_q;
          rx_state_q   <= rx_s2_q ? RX_IDLE : RX_BREAK;
        end
        RX_BREAK: if (rx_s2_q) rx_state_q <= RX_IDLE;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xcvr.sv
// tb/tb_uart_xcvr.sv - directed self-checking bench for uart_xcvr at CLK_DIV=4, 8 data bits, odd parity
module tb_uart_xcvr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cmd_in;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        tx;
  logic        rx;
  logic [7:0]  read_data;
  logic        read_vld;
  logic        parity_err;
  logic        frame_err;
`ifdef UART_LOOPBACK_EN
  logic        loop_en;
`endif

  int total = 0;
  int bad   = 0;
  int rv_cnt = 0;
  logic [7:0] rv_data;
  logic       rv_pe;
  logic       rv_fe;
  logic [7:0] rv_hist[$];
  int tx_low = 0;

  always #5 clk = ~clk;

  uart_xcvr #(.CLK_DIV(4), .DATA_W(8), .NUM_BYTES(2), .PARITY(1)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_LOOPBACK_EN
    .loop_en(loop_en),
`endif
    .cmd_in(cmd_in), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .tx(tx), .rx(rx),
    .read_data(read_data), .read_vld(read_vld), .parity_err(parity_err), .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (read_vld === 1'b1) begin
      rv_data = read_data;
      rv_pe   = parity_err;
      rv_fe   = frame_err;
      rv_hist.push_back(read_data);
      rv_cnt  = rv_cnt + 1;
    end
    if (tx !== 1'b1) tx_low = tx_low + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    logic [21:0] exp_seq;
    int c0;
    int tl0;
    exp_seq = {1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
    rst_n = 1'b0; rx = 1'b1; cmd_vld = 1'b0; cmd_in = '0;
`ifdef UART_LOOPBACK_EN
    loop_en = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 1);
    chk("rst_read_vld", 32'(read_vld), 0);
    chk("rst_read_data", 32'(read_data), 0);
    chk("rst_parity_err", 32'(parity_err), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // command A55A, with a 1234 request injected mid-command that must be ignored
    cmd_in = 16'hA55A; cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    for (int i = 0; i < 88; i++) begin
      chk($sformatf("t1_tx_c%0d", i), 32'(tx), 32'(exp_seq[i / 4]));
      chk($sformatf("t1_rdy_c%0d", i), 32'(cmd_rdy), 0);
      if (i == 20) begin cmd_in = 16'h1234; cmd_vld = 1'b1; end
      if (i == 21) cmd_vld = 1'b0;
      @(negedge clk);
    end
    chk("t1_rdy_back", 32'(cmd_rdy), 1);
    chk("t1_tx_idle", 32'(tx), 1);

    c0 = rv_cnt;
    send_rx(8'h3C, 1'b1, 1'b1);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    chk("t2_cnt", 32'(rv_cnt - c0), 1);
    chk("t2_data", 32'(rv_data), 32'h3C);
    chk("t2_pe", 32'(rv_pe), 0);
    chk("t2_fe", 32'(rv_fe), 0);

    c0 = rv_cnt;
    send_rx(8'h01, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    chk("t3a_cnt", 32'(rv_cnt - c0), 1);
    chk("t3a_data", 32'(rv_data), 32'h01);
    chk("t3a_pe", 32'(rv_pe), 1);
    chk("t3a_fe", 32'(rv_fe), 0);

    c0 = rv_cnt;
    send_rx(8'h01, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    chk("t3b_cnt", 32'(rv_cnt - c0), 1);
    chk("t3b_data", 32'(rv_data), 32'h01);
    chk("t3b_pe", 32'(rv_pe), 0);
    chk("t3b_fe", 32'(rv_fe), 1);
    repeat (60) @(negedge clk);
    chk("t3b_break_hold", 32'(rv_cnt - c0), 1);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    c0 = rv_cnt;
    send_rx(8'hC3, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    chk("t3b_rearm_cnt", 32'(rv_cnt - c0), 1);
    chk("t3b_rearm_data", 32'(rv_data), 32'hC3);
    chk("t3b_rearm_fe", 32'(rv_fe), 0);

    c0 = rv_cnt;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("t4_glitch_cnt", 32'(rv_cnt - c0), 0);
    send_rx(8'h5A, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    chk("t4_after_cnt", 32'(rv_cnt - c0), 1);
    chk("t4_after_data", 32'(rv_data), 32'h5A);
    chk("t4_after_pe", 32'(rv_pe), 0);

    // reset in the middle of a TX frame and a partial RX frame
    c0 = rv_cnt;
    cmd_in = 16'hC381; cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    rx = 1'b0;
    repeat (13) @(negedge clk);
    chk("t5_tx_busy", 32'(tx), 0);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async_tx", 32'(tx), 1);
    chk("t5_async_rdy", 32'(cmd_rdy), 1);
    chk("t5_async_vld", 32'(read_vld), 0);
    chk("t5_async_data", 32'(read_data), 0);
    @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("t5_no_vld", 32'(rv_cnt - c0), 0);
    chk("t5_tx_idle", 32'(tx), 1);
    chk("t5_rdy_idle", 32'(cmd_rdy), 1);

`ifdef UART_LOOPBACK_EN
    c0 = rv_cnt;
    tl0 = tx_low;
    loop_en = 1'b1;
    cmd_in = 16'hC381; cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    repeat (100) @(negedge clk);
    chk("t6_cnt", 32'(rv_cnt - c0), 2);
    if (rv_cnt - c0 == 2) begin
      chk("t6_first", 32'(rv_hist[c0]), 32'hC3);
      chk("t6_second", 32'(rv_hist[c0 + 1]), 32'h81);
    end
    chk("t6_pe", 32'(rv_pe), 0);
    chk("t6_fe", 32'(rv_fe), 0);
    chk("t6_tx_pin_high", 32'(tx_low - tl0), 0);
    chk("t6_rdy", 32'(cmd_rdy), 1);
    loop_en = 1'b0;
`else
    tl0 = tx_low;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
